ctrl_desp32: RTL and testbench
==============================

# ctrl_desp32

Sequencer for the 32-bit shift-register datapath (eight 4-bit slices chained through serial carry). It accepts one command per transaction over a valid/ready handshake and drives the register's enable, direction, mode, serial-in and parallel-load lines. It parallel-loads a word, then shifts or rotates it a programmed number of positions while capturing every serial-out bit. It returns the final register contents and the captured bit stream over a second valid/ready handshake. Sits between the bus-side command logic and the `RegDesp32` instance.

## Interface
- `MAX_CNT`, default 32: largest honoured shift count; larger requests clamp to it.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `cmd_valid` in 1: command present.
- `cmd_ready` out 1: controller accepts a command this cycle.
- `cmd_op` in 2: 00 shift, 01 rotate, 10 load-only, 11 treated as load-only.
- `cmd_dir` in 1: 1 = toward MSB (`sIn` enters bit 0, `sOut` is bit 31); 0 = toward LSB (`sIn` enters bit 31, `sOut` is bit 0).
- `cmd_sin` in 1: fill bit for shift op.
- `cmd_cnt` in 6: positions to move, 0..63.
- `cmd_data` in 32: word to load.
- `abort` in 1: terminate shifting early.
- `res_valid` out 1: result available.
- `res_ready` in 1: result consumed.
- `res_q` out 32: register contents after operation.
- `res_sout` out 32: captured serial-out bits, bit i = i-th bit shifted out.
- `res_cnt` out 6: shifts actually performed.
- `reg_enb`, `reg_dir`, `reg_sin` out 1 each; `reg_modo` out 2; `reg_d` out 32: to register.
- `reg_q` in 32, `reg_sout` in 1: from register.

## Operation
- Mode encoding (shared constants): `MODO_DESP`=00 shift, `MODO_ROT`=01 rotate, `MODO_CARGA`=10 parallel load, 11 unused (never driven). `reg_enb`=0 holds the register.
- FSM states: IDLE, LOAD, SHIFT, RESULT.
  - IDLE: `cmd_ready`=1. On `cmd_valid`, latch the command. Clamp the count to `MAX_CNT`, and force it to 0 for load-only. Go to LOAD.
  - LOAD: one cycle. `reg_enb`=1, `reg_modo`=CARGA, `reg_d`=latched data. Next state is SHIFT if count>0, else RESULT.
  - SHIFT: one position per cycle. `reg_enb`=1, `reg_modo`=DESP or ROT, `reg_dir`/`reg_sin` from the command. At each edge, `reg_sout` is written into `res_sout[k]`, where k = shifts done so far, and k increments. Exit to RESULT when k reaches the count.
  - RESULT: `reg_enb`=0. `res_valid`=1, `res_q`=`reg_q`, `res_sout` and `res_cnt` stay stable. On `res_ready`, go to IDLE. `cmd_ready`=0 in this state.
- `abort` is sampled in SHIFT only. The shift in that same cycle still completes and is captured, then the FSM goes to RESULT. If `abort` is asserted on the final shift cycle, the result is the same as the normal exit. `abort` is ignored in other states.
- `res_sout` is cleared in LOAD, so uncaptured bits read 0.
- `reg_*` outputs are registered: they are valid for the whole state and glitch-free.

## Timing
- Command accepted at edge T. LOAD occupies cycle T..T+1. Shifts occupy the following N cycles. `res_valid` rises after edge T+1+N, so latency is N+2 edges.
- Load-only or N=0: `res_valid` appears 2 edges after acceptance.
- Throughput: after `res_ready`, IDLE lasts at least one cycle before the next acceptance.
- Reset values: state IDLE, `cmd_ready`=1, `res_valid`=0, `res_q` follows `reg_q`, `res_sout`=0, `res_cnt`=0, `reg_enb`=0, `reg_modo`=00, `reg_dir`=0, `reg_sin`=0, `reg_d`=0.
- Reset mid-operation aborts immediately. No result is produced. Register contents are undefined afterwards, because the datapath has no reset.

## Structure
- Package `desp_pkg`: `MODO_*` constants, `cmd_op` encodings, and the FSM state enum.
- No sub-module is needed. The shift counter and capture register are inline. A top-level test wrapper instantiates `ctrl_desp32` plus `RegDesp32`.

## Test plan
- Load-only with 0xDEADBEEF: `res_q`=0xDEADBEEF, `res_cnt`=0, `res_sout`=0, `res_valid` 2 edges after acceptance.
- Shift, dir=1, sin=0, cnt=4, data 0xF000000F: `res_q`=0x000000F0, `res_sout`=0x0000000F, `res_cnt`=4, latency 6.
- Rotate, dir=0, cnt=8, data 0x12345678: `res_q`=0x78123456, `res_sout`=0x00000078 (bits out: 0,0,0,1,1,1,1,0).
- cnt=40, shift, dir=1, sin=1, data 0: `res_cnt`=32, `res_q`=0xFFFFFFFF, `res_sout`=0.
- Abort asserted on 3rd shift cycle of cnt=10: `res_cnt`=3. Then hold `res_ready`=0 for 5 cycles: outputs stable, `cmd_ready`=0.
- `rst_n` pulse during SHIFT: on the next cycle `cmd_ready`=1, `res_valid`=0, `reg_enb`=0.

Source files
------------

// File: rtl/desp_pkg.sv
// Shared encodings for the 32-bit shift-register datapath and its sequencer.
// Holds the mode lines seen by RegDesp32, the command opcodes and the FSM states.
package desp_pkg;

    localparam logic [1:0] MODO_DESP  = 2'b00;
    localparam logic [1:0] MODO_ROT   = 2'b01;
    localparam logic [1:0] MODO_CARGA = 2'b10;

    localparam logic [1:0] OP_SHIFT    = 2'b00;
    localparam logic [1:0] OP_ROT      = 2'b01;
    localparam logic [1:0] OP_LOAD     = 2'b10;
    localparam logic [1:0] OP_LOAD_ALT = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SHIFT,
        ST_RESULT
    } state_t;

    // Positions to move: zero for either load-only opcode, else clamped to max_cnt.
    function automatic logic [5:0] eff_cnt(input logic [1:0] op,
                                           input logic [5:0] cnt,
                                           input logic [5:0] max_cnt);
        if (op == OP_LOAD || op == OP_LOAD_ALT)
            return 6'd0;
        else if (cnt > max_cnt)
            return max_cnt;
        else
            return cnt;
    endfunction

endpackage

// File: rtl/ctrl_desp32.sv
// Sequencer for RegDesp32: loads a word, shifts/rotates it N positions while
// capturing each serial-out bit, then presents the result over valid/ready.
module ctrl_desp32
    import desp_pkg::*;
#(
    parameter int MAX_CNT = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic        cmd_dir,
    input  logic        cmd_sin,
    input  logic [5:0]  cmd_cnt,
    input  logic [31:0] cmd_data,
    input  logic        abort,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [31:0] res_q,
    output logic [31:0] res_sout,
    output logic [5:0]  res_cnt,
    output logic        reg_enb,
    output logic        reg_dir,
    output logic        reg_sin,
    output logic [1:0]  reg_modo,
    output logic [31:0] reg_d,
    input  logic [31:0] reg_q,
    input  logic        reg_sout
);

    localparam logic [5:0] MAX_CNT_W = 6'(MAX_CNT);

    state_t      state_q;
    logic [1:0]  modo_sh_q;
    logic [5:0]  cnt_q;
    logic [5:0]  k_q;
    logic [5:0]  k_d;
    logic [31:0] sout_q;
    logic        reg_enb_q;
    logic        reg_dir_q;
    logic        reg_sin_q;
    logic [1:0]  reg_modo_q;
    logic [31:0] reg_d_q;

    assign k_d = k_q + 6'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            modo_sh_q  <= MODO_DESP;
            cnt_q      <= '0;
            k_q        <= '0;
            sout_q     <= '0;
            reg_enb_q  <= 1'b0;
            reg_dir_q  <= 1'b0;
            reg_sin_q  <= 1'b0;
            reg_modo_q <= MODO_DESP;
            reg_d_q    <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        state_q    <= ST_LOAD;
                        cnt_q      <= eff_cnt(cmd_op, cmd_cnt, MAX_CNT_W);
                        modo_sh_q  <= (cmd_op == OP_ROT) ? MODO_ROT : MODO_DESP;
                        reg_dir_q  <= cmd_dir;
                        reg_sin_q  <= cmd_sin;
                        reg_enb_q  <= 1'b1;
                        reg_modo_q <= MODO_CARGA;
                        reg_d_q    <= cmd_data;
                    end
                end
                ST_LOAD: begin
                    k_q    <= '0;
                    sout_q <= '0;
                    if (cnt_q != 6'd0) begin
                        state_q    <= ST_SHIFT;
                        reg_modo_q <= modo_sh_q;
                    end else begin
                        state_q    <= ST_RESULT;
                        reg_enb_q  <= 1'b0;
                        reg_modo_q <= MODO_DESP;
                    end
                end
                ST_SHIFT: begin
                    // reg_sout shows the bit leaving on this edge's shift.
                    if (k_q < 6'd32)
                        sout_q[k_q[4:0]] <= reg_sout;
                    k_q <= k_d;
                    if (abort || k_d >= cnt_q) begin
                        state_q    <= ST_RESULT;
                        reg_enb_q  <= 1'b0;
                        reg_modo_q <= MODO_DESP;
                    end
                end
                ST_RESULT: begin
                    if (res_ready)
                        state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign cmd_ready = (state_q == ST_IDLE);
    assign res_valid = (state_q == ST_RESULT);
    assign res_q     = reg_q;
    assign res_sout  = sout_q;
    assign res_cnt   = k_q;
    assign reg_enb   = reg_enb_q;
    assign reg_dir   = reg_dir_q;
    assign reg_sin   = reg_sin_q;
    assign reg_modo  = reg_modo_q;
    assign reg_d     = reg_d_q;

endmodule

// File: tb/tb_ctrl_desp32.sv
// Directed bench for ctrl_desp32 driving a behavioural 32-bit shift register;
// expected results are hand-computed per transaction.
module tb_ctrl_desp32;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid, cmd_ready;
    logic [1:0]  cmd_op;
    logic        cmd_dir, cmd_sin;
    logic [5:0]  cmd_cnt;
    logic [31:0] cmd_data;
    logic        abort;
    logic        res_valid, res_ready;
    logic [31:0] res_q, res_sout;
    logic [5:0]  res_cnt;
    logic        reg_enb, reg_dir, reg_sin;
    logic [1:0]  reg_modo;
    logic [31:0] reg_d, reg_q;
    logic        reg_sout;
    logic [31:0] rq;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    ctrl_desp32 #(.MAX_CNT(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_dir(cmd_dir), .cmd_sin(cmd_sin), .cmd_cnt(cmd_cnt), .cmd_data(cmd_data),
        .abort(abort),
        .res_valid(res_valid), .res_ready(res_ready), .res_q(res_q),
        .res_sout(res_sout), .res_cnt(res_cnt),
        .reg_enb(reg_enb), .reg_dir(reg_dir), .reg_sin(reg_sin), .reg_modo(reg_modo),
        .reg_d(reg_d), .reg_q(reg_q), .reg_sout(reg_sout)
    );

    // RegDesp32 stand-in: no reset, serial-out is the bit about to leave.
    always_ff @(posedge clk) begin
        if (reg_enb) begin
            case (reg_modo)
                2'b10:   rq <= reg_d;
                2'b00:   rq <= reg_dir ? {rq[30:0], reg_sin} : {reg_sin, rq[31:1]};
                2'b01:   rq <= reg_dir ? {rq[30:0], rq[31]} : {rq[0], rq[31:1]};
                default: rq <= rq;
            endcase
        end
    end
    assign reg_q    = rq;
    assign reg_sout = reg_dir ? rq[31] : rq[0];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic run_cmd(input string name, input logic [1:0] op, input logic dir,
                           input logic sin, input logic [5:0] cnt, input logic [31:0] data,
                           input int abort_at, input int hold,
                           input logic [31:0] exp_q, input logic [31:0] exp_sout,
                           input logic [5:0] exp_cnt, input int exp_lat);
        int  e;
        bit  seen;
        @(negedge clk);
        chk({name, " cmd_ready_idle"}, 32'(cmd_ready), 32'd1);
        cmd_op = op; cmd_dir = dir; cmd_sin = sin; cmd_cnt = cnt; cmd_data = data;
        cmd_valid = 1'b1;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        cmd_data = 32'h0;
        @(negedge clk);
        chk({name, " load_enb"}, 32'(reg_enb), 32'd1);
        chk({name, " load_modo"}, 32'(reg_modo), 32'd2);
        chk({name, " load_d"}, reg_d, data);
        e = 0;
        seen = 1'b0;
        while (!seen && e < 80) begin
            @(posedge clk);
            e++;
            #1 abort = (e == abort_at);
            @(negedge clk);
            if (res_valid) seen = 1'b1;
        end
        abort = 1'b0;
        chk({name, " latency"}, seen ? 32'(e + 1) : 32'hFFFF_FFFF, 32'(exp_lat));
        chk({name, " res_q"}, res_q, exp_q);
        chk({name, " res_sout"}, res_sout, exp_sout);
        chk({name, " res_cnt"}, 32'(res_cnt), 32'(exp_cnt));
        chk({name, " cmd_ready_busy"}, 32'(cmd_ready), 32'd0);
        chk({name, " enb_result"}, 32'(reg_enb), 32'd0);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            chk({name, " hold_valid"}, 32'(res_valid), 32'd1);
            chk({name, " hold_ready"}, 32'(cmd_ready), 32'd0);
            chk({name, " hold_q"}, res_q, exp_q);
            chk({name, " hold_sout"}, res_sout, exp_sout);
            chk({name, " hold_cnt"}, 32'(res_cnt), 32'(exp_cnt));
        end
        res_ready = 1'b1;
        @(posedge clk);
        #1 res_ready = 1'b0;
        @(negedge clk);
        chk({name, " done_valid"}, 32'(res_valid), 32'd0);
        chk({name, " done_ready"}, 32'(cmd_ready), 32'd1);
        $display("txn %-10s op=%b dir=%b cnt=%0d data=%h -> q=%h sout=%h n=%0d lat=%0d",
                 name, op, dir, cnt, data, exp_q, exp_sout, exp_cnt, exp_lat);
    endtask

    initial begin
        rst_n = 1'b0;
        cmd_valid = 1'b0; cmd_op = 2'b00; cmd_dir = 1'b0; cmd_sin = 1'b0;
        cmd_cnt = 6'd0; cmd_data = 32'h0; abort = 1'b0; res_ready = 1'b0;
        #3;
        chk("rst cmd_ready", 32'(cmd_ready), 32'd1);
        chk("rst res_valid", 32'(res_valid), 32'd0);
        chk("rst res_sout", res_sout, 32'd0);
        chk("rst res_cnt", 32'(res_cnt), 32'd0);
        chk("rst reg_enb", 32'(reg_enb), 32'd0);
        chk("rst reg_modo", 32'(reg_modo), 32'd0);
        chk("rst reg_dir", 32'(reg_dir), 32'd0);
        chk("rst reg_sin", 32'(reg_sin), 32'd0);
        chk("rst reg_d", reg_d, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        run_cmd("load",     2'b10, 1'b0, 1'b0, 6'd5,  32'hDEADBEEF, 0, 0, 32'hDEADBEEF, 32'h0,        6'd0,  2);
        run_cmd("shl4",     2'b00, 1'b1, 1'b0, 6'd4,  32'hF000000F, 0, 0, 32'h000000F0, 32'h0000000F, 6'd4,  6);
        run_cmd("rotr8",    2'b01, 1'b0, 1'b0, 6'd8,  32'h12345678, 0, 0, 32'h78123456, 32'h00000078, 6'd8,  10);
        run_cmd("clamp40",  2'b00, 1'b1, 1'b1, 6'd40, 32'h00000000, 0, 0, 32'hFFFFFFFF, 32'h00000000, 6'd32, 34);
        run_cmd("abort3",   2'b00, 1'b1, 1'b0, 6'd10, 32'hA0000001, 3, 5, 32'h00000008, 32'h00000005, 6'd3,  5);
        run_cmd("shr4",     2'b00, 1'b0, 1'b1, 6'd4,  32'h0000000A, 0, 0, 32'hF0000000, 32'h0000000A, 6'd4,  6);
        run_cmd("rotl32",   2'b01, 1'b1, 1'b0, 6'd32, 32'h80000001, 0, 0, 32'h80000001, 32'h80000001, 6'd32, 34);
        run_cmd("op11",     2'b11, 1'b1, 1'b1, 6'd7,  32'h0F0F0F0F, 0, 0, 32'h0F0F0F0F, 32'h0,        6'd0,  2);
        run_cmd("cnt0",     2'b00, 1'b1, 1'b0, 6'd0,  32'h12345678, 0, 0, 32'h12345678, 32'h0,        6'd0,  2);
        run_cmd("abortlast",2'b00, 1'b1, 1'b0, 6'd2,  32'hC0000000, 2, 0, 32'h00000000, 32'h00000003, 6'd2,  4);

        // Reset pulse in the middle of a long shift.
        @(negedge clk);
        cmd_op = 2'b00; cmd_dir = 1'b1; cmd_sin = 1'b0; cmd_cnt = 6'd10;
        cmd_data = 32'h5555AAAA; cmd_valid = 1'b1;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("midrst pre_enb", 32'(reg_enb), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("midrst cmd_ready", 32'(cmd_ready), 32'd1);
        chk("midrst res_valid", 32'(res_valid), 32'd0);
        chk("midrst reg_enb", 32'(reg_enb), 32'd0);
        @(posedge clk);
        @(negedge clk);
        chk("midrst next_ready", 32'(cmd_ready), 32'd1);
        chk("midrst next_valid", 32'(res_valid), 32'd0);
        chk("midrst next_enb", 32'(reg_enb), 32'd0);
        chk("midrst res_cnt", 32'(res_cnt), 32'd0);
        rst_n = 1'b1;
        $display("txn %-10s reset pulse during SHIFT", "midrst");

        run_cmd("reload",   2'b10, 1'b0, 1'b0, 6'd0,  32'hCAFEF00D, 0, 0, 32'hCAFEF00D, 32'h0,        6'd0,  2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
